bot_io_hub: RTL

- Parametrised PicoBlaze I/O and interrupt hub for the Nexys4 robot design.
- Replaces the fixed 8-digit / 16-LED port map with a width-generic register map.
- Adds a multi-source interrupt controller with pending, mask and vector registers.
- Sits between the PicoBlaze port bus and the board peripherals (buttons, switches, LEDs, 7-segment driver, bot simulator registers, motor control).

---
 rtl/bot_io_hub.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/bot_io_hub.sv
// PicoBlaze port-bus I/O hub for the Nexys4 robot: width-generic register map
// plus an edge-triggered, maskable, priority-encoded interrupt controller.
module bot_io_hub #(
   parameter int           NUM_DIGITS    = 8,
   parameter int           NUM_SW_BYTES  = 2,
   parameter int           NUM_LED_BYTES = 2,
   parameter int           NUM_IRQ       = 4,
   parameter logic [4:0]   DIG_RST       = 5'h1F
) (
   input  logic                         sysclk,
   input  logic                         sysreset,
   input  logic [7:0]                   port_id,
   input  logic [7:0]                   io_data_in,
   output logic [7:0]                   io_data_out,
   input  logic                         write_strobe,
   input  logic                         k_write_strobe,
   input  logic                         read_strobe,
   output logic                         interrupt,
   input  logic                         interrupt_ack,
   input  logic [NUM_IRQ-1:0]           irq_src,
   input  logic [5:0]                   dbbtns,
   input  logic [8*NUM_SW_BYTES-1:0]    switches,
   input  logic [7:0]                   locx,
   input  logic [7:0]                   locy,
   input  logic [7:0]                   botinfo,
   input  logic [7:0]                   sensors,
   input  logic [7:0]                   lmdist,
   input  logic [7:0]                   rmdist,
   output logic [7:0]                   mot_ctl,
   output logic [5*NUM_DIGITS-1:0]      digits,
   output logic [NUM_DIGITS-1:0]        dp,
   output logic [8*NUM_LED_BYTES-1:0]   leds
);

   logic                  we;
   logic [NUM_IRQ-1:0]    irq_pend;
   logic [NUM_IRQ-1:0]    irq_mask;
   logic [NUM_IRQ-1:0]    irq_prev;
   logic [NUM_IRQ-1:0]    pend_set;
   logic [NUM_IRQ-1:0]    ack_clr;
   logic [NUM_IRQ-1:0]    w1c_clr;
   logic [NUM_IRQ-1:0]    active;
   logic                  any;
   logic [2:0]            idx;
   logic [7:0]            irq_vec;
   logic [7:0]            rd_mux;
   logic [15:0]           dp_pad;
   logic [15:0]           dp_wr;
   logic                  unused_sig;

   assign we = write_strobe | k_write_strobe;

   assign active   = irq_pend & irq_mask;
   assign any      = |active;
   assign pend_set = irq_src & ~irq_prev;
   assign ack_clr  = (interrupt_ack && any) ? (NUM_IRQ'(1) << idx) : '0;
   assign w1c_clr  = (we && port_id == 8'h01) ? io_data_in[NUM_IRQ-1:0] : '0;
   assign irq_vec  = any ? {1'b1, 4'b0000, idx} : 8'h00;

   // lowest active index has priority
   always_comb begin
      idx = 3'd0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (active[i]) idx = 3'(i);
      end
   end

   // dp is handled as a 16-bit view so unmapped bits fall away on write
   assign dp_pad = 16'(dp);

   always_comb begin
      dp_wr = dp_pad;
      if (we && port_id == 8'h0C) dp_wr[7:0]  = io_data_in;
      if (we && port_id == 8'h0D) dp_wr[15:8] = io_data_in;
   end

   always_comb begin
      rd_mux = 8'h00;
      case (port_id)
         8'h00:   rd_mux = {2'b00, dbbtns};
         8'h01:   rd_mux = 8'(irq_pend);
         8'h02:   rd_mux = 8'(irq_mask);
         8'h03:   rd_mux = irq_vec;
         8'h04:   rd_mux = mot_ctl;
         8'h05:   rd_mux = locx;
         8'h06:   rd_mux = locy;
         8'h07:   rd_mux = botinfo;
         8'h08:   rd_mux = sensors;
         8'h09:   rd_mux = lmdist;
         8'h0A:   rd_mux = rmdist;
         8'h0C:   rd_mux = dp_pad[7:0];
         8'h0D:   rd_mux = dp_pad[15:8];
         default: rd_mux = 8'h00;
      endcase
      for (int i = 0; i < NUM_SW_BYTES; i++) begin
         if (port_id == 8'(16 + i)) rd_mux = switches[8*i +: 8];
      end
      for (int i = 0; i < NUM_LED_BYTES; i++) begin
         if (port_id == 8'(24 + i)) rd_mux = leds[8*i +: 8];
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (port_id == 8'(32 + i)) rd_mux = {3'b000, digits[5*i +: 5]};
      end
   end

   // interrupt controller; a new edge always beats ack or W1C on the same bit
   always_ff @(posedge sysclk or posedge sysreset) begin
      if (sysreset) begin
         irq_pend  <= '0;
         irq_mask  <= NUM_IRQ'(1);
         irq_prev  <= '0;
         interrupt <= 1'b0;
      end else begin
         irq_prev  <= irq_src;
         irq_pend  <= (irq_pend & ~ack_clr & ~w1c_clr) | pend_set;
         interrupt <= any;
         if (we && port_id == 8'h02) irq_mask <= io_data_in[NUM_IRQ-1:0];
      end
   end

   always_ff @(posedge sysclk or posedge sysreset) begin
      if (sysreset) begin
         io_data_out <= 8'h00;
         mot_ctl     <= 8'h00;
         leds        <= '0;
         dp          <= '0;
         digits      <= {NUM_DIGITS{DIG_RST}};
      end else begin
         io_data_out <= rd_mux;
         dp          <= dp_wr[NUM_DIGITS-1:0];
         if (we && port_id == 8'h04) mot_ctl <= io_data_in;
         for (int i = 0; i < NUM_LED_BYTES; i++) begin
            if (we && port_id == 8'(24 + i)) leds[8*i +: 8] <= io_data_in;
         end
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (we && port_id == 8'(32 + i)) digits[5*i +: 5] <= io_data_in[4:0];
         end
      end
   end

   assign unused_sig = &{1'b0, read_strobe, dp_wr};

endmodule
